// File: rtl/day3_pkg.sv
// Purpose: shared state encoding and widths for the debounce/edge block.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the block has no handshake.
`timescale 1ns/1ps
package day3_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int EDGE_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// Purpose: N-flop synchronizer that brings a raw level into the clk domain.
// Latency: N rising edges from d_i to q_o.
// Backpressure: none; samples every edge.
`timescale 1ns/1ps
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] stages;

  // Shift the raw input through the flop chain; stage 0 is the metastable-prone one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[N-2:0], d_i};
    end
  end

  assign q_o = stages[N-1];

endmodule

// File: rtl/sync_debounce_edge.sv
// Purpose: synchronize + debounce a raw bit; clean level, rise/fall pulses, busy flag.
// Latency: level/pulse update on edge SYNC_STAGES+DEBOUNCE_CYCLES after d_i changes.
// Backpressure: none; optional rise counter under SYNC_DEBOUNCE_EDGE_EDGE_COUNT_EN.
`timescale 1ns/1ps
module sync_debounce_edge
  import day3_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
`ifdef SYNC_DEBOUNCE_EDGE_EDGE_COUNT_EN
  ,
  output logic [EDGE_CNT_W-1:0] rise_cnt_o
`endif
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_t        state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             level_q, level_n;
  logic             rise_q, rise_n;
  logic             fall_q, fall_n;
  logic             busy_q, busy_n;

  sync_chain #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (d_i),
    .q_o  (s)
  );

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      level_q <= level_n;
      rise_q  <= rise_n;
      fall_q  <= fall_n;
      busy_q  <= busy_n;
    end
  end

  // Qualification: a new level is accepted after DEBOUNCE_CYCLES identical samples;
  // any opposite sample during a wait drops back to the current stable level.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    level_n = level_q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_n = WAIT_HIGH;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
          level_n = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_n = WAIT_LOW;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
          level_n = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
    busy_n = (state_n == WAIT_HIGH) || (state_n == WAIT_LOW);
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = busy_q;

`ifdef SYNC_DEBOUNCE_EDGE_EDGE_COUNT_EN
  logic [EDGE_CNT_W-1:0] rise_cnt_q;

  // Count accepted rising edges; wraps naturally at the counter width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_cnt_q <= '0;
    end else if (rise_q) begin
      rise_cnt_q <= rise_cnt_q + 1'b1;
    end
  end

  assign rise_cnt_o = rise_cnt_q;
`else
  // Without the counter the block exposes only level, pulses and busy.
`endif

endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Downstream consumer of the flop-based data path. It takes a raw, possibly asynchronous or bouncy single-bit input `d_i`.
- It synchronizes `d_i` through an N-stage flop chain, then debounces it with a counter FSM.
- Outputs are a clean registered level plus one-cycle rise and fall pulses. These feed the later edge/event logic in the design.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2 or more.
- DEBOUNCE_CYCLES, 4, number of consecutive identical synchronized samples needed to accept a new level; legal range 2 or more.

Ports:
- clk, input, 1, sole clock, rising-edge.
- reset, input, 1, asynchronous, active-high reset for all flops.
- d_i, input, 1, raw input level.
- level_o, output, 1, debounced registered level.
- rise_o, output, 1, one-cycle pulse when level_o goes 0->1.
- fall_o, output, 1, one-cycle pulse when level_o goes 1->0.
- busy_o, output, 1, high while a level change is being qualified.
- rise_cnt_o, output, 8, rising-edge count; present only with EDGE_COUNT_EN.

Behaviour:
- Reset:
  - Asynchronous, active-high, takes effect immediately, mid-operation included.
  - Clears sync chain, counter and pulses.
  - State goes to IDLE_LOW.
  - level_o=0, rise_o=0, fall_o=0, busy_o=0.
- Synchronizer:
  - d_i passes through SYNC_STAGES flops.
  - s = output of the last flop.
- Counter:
  - Width CNT_W = $clog2(DEBOUNCE_CYCLES)+1.
  - Unsigned.
  - Never exceeds DEBOUNCE_CYCLES-1.
- FSM, evaluated every rising clk edge on s:
  - IDLE_LOW:
    - s=1 -> WAIT_HIGH, cnt=1.
    - Otherwise stay, cnt=0.
  - WAIT_HIGH:
    - s=0 -> IDLE_LOW, cnt=0. This is glitch rejection; no pulse.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE_HIGH, level_o<=1, rise_o<=1.
    - Otherwise cnt++.
  - IDLE_HIGH:
    - s=0 -> WAIT_LOW, cnt=1.
    - Otherwise stay.
  - WAIT_LOW:
    - Mirror of WAIT_HIGH.
    - s=1 aborts to IDLE_HIGH.
    - Completion -> IDLE_LOW, level_o<=0, fall_o<=1.
- Pulses:
  - rise_o and fall_o are registered and high for exactly one cycle.
  - They are mutually exclusive.
  - Both are cleared on the following edge.
- busy_o is registered and high exactly while the state is WAIT_HIGH or WAIT_LOW.
- Latency:
  - Count the first rising edge that samples the new d_i value as edge 1.
  - A clean change on d_i updates level_o and pulses rise_o/fall_o on edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - With defaults this is edge 6.
- Glitch threshold:
  - An input held for DEBOUNCE_CYCLES-1 cycles is rejected: no level change, no pulse.
  - An input held for DEBOUNCE_CYCLES cycles is accepted.
- Bounce during WAIT:
  - Any opposite sample returns to the stable state.
  - Qualification restarts from cnt=1 on the next change.
- Reset deasserted while d_i=1:
  - The block starts from IDLE_LOW.
  - It produces a normal rise_o after the standard latency.

Optional Feature:
- Macro: SYNC_DEBOUNCE_EDGE_EDGE_COUNT_EN.
- Defined:
  - Adds port rise_cnt_o, an 8-bit register.
  - Reset value 0.
  - Increments on each cycle rise_o=1.
  - Wraps 255->0 without saturation.
  - fall_o has no effect on it.
- Undefined:
  - rise_cnt_o port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package day3_pkg holds:
  - Typedef enum logic [1:0] db_state_t {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW}.
  - Localparam EDGE_CNT_W = 8.
- One sub-module, sync_chain:
  - Parameter N = number of stages.
  - Ports clk, reset, d_i, q_o.
  - Asynchronous active-high reset to 0.
  - Instantiated once for the synchronizer.
- The FSM and counter stay in the top module.

Test Plan:
- All scenarios use the defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset held for 2 cycles with d_i=0, then released -> level_o=0, rise_o=0, fall_o=0, busy_o=0 throughout. rise_cnt_o=0 when the macro is defined.
- d_i 0->1 held for 10 cycles -> busy_o high on edges 3-5, level_o=1 and rise_o=1 for exactly one cycle on edge 6, busy_o=0.
- d_i high for 3 cycles, then low -> busy_o pulses, and level_o, rise_o and fall_o stay 0.
- From level_o=1, d_i toggles 1,0,1,0 per cycle for 4 cycles, then holds 0 -> no premature fall_o. fall_o is a single pulse 6 edges after the final 1->0; level_o=0.
- Reset asserted on a negedge while in WAIT_HIGH with cnt=2, d_i kept 1 -> outputs clear immediately. After release, rise_o fires exactly 6 edges later.
- With SYNC_DEBOUNCE_EDGE_EDGE_COUNT_EN defined, 257 accepted rising edges -> rise_cnt_o reads 1, confirming wrap.
